pht_ctrl: RTL and testbench
===========================

Name: pht_ctrl

Overview:
Access controller for a single-ported 2-bit-counter pattern history RAM in the branch prediction buffer. It arbitrates the one table port between fetch-stage lookups and a queue of resolved-branch updates from decode. Updates use read-modify-write with saturating counters. After reset or flush, the block sweeps the table to weakly-not-taken.

Parameters:
INDEX_WIDTH, 6, table index width; table holds 2**INDEX_WIDTH entries
QUEUE_DEPTH, 4, update FIFO depth; power of two, >=2
STARVE_LIMIT, 8, consecutive lookup-blocked cycles with a pending update before the update is forced; >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-low
en_i  in  1  pipeline enable; 0 freezes all state
flush_i  in  1  restart init sweep and discard queued updates
lookup_valid_i  in  1  fetch requests a prediction
lookup_index_i  in  INDEX_WIDTH  fetch index
pred_valid_o  out  1  pred_taken_o is meaningful this cycle
pred_taken_o  out  1  predicted direction (counter MSB)
upd_valid_i  in  1  resolved branch outcome offered
upd_index_i  in  INDEX_WIDTH  index to update
upd_taken_i  in  1  actual outcome
upd_ready_o  out  1  queue can accept (not full)
tbl_en_o  out  1  RAM access this cycle
tbl_we_o  out  1  write (1) / read (0)
tbl_addr_o  out  INDEX_WIDTH  RAM address
tbl_wdata_o  out  2  write data
tbl_rdata_i  in  2  read data, 1-cycle latency after a read
init_done_o  out  1  sweep complete
busy_o  out  1  sweep active or queue non-empty

Behaviour:
- Reset (rst_i=0 at posedge): state INIT, sweep pointer 0, queue empty, starve counter 0. Outputs: pred_valid_o=0, init_done_o=0, tbl_en_o=0. upd_ready_o=1 after reset.
- FSM states: INIT, IDLE, UPD_RD, UPD_WR.
  - INIT: each enabled cycle, write 2'b01 to sweep pointer and increment it. After address 2**INDEX_WIDTH-1, go IDLE and set init_done_o=1 the next cycle. Lookups are not granted during INIT. Updates are accepted into the queue but not drained.
- Port priority outside INIT: lookup first, then update, except when the starve counter has reached STARVE_LIMIT.
  - IDLE: lookup_valid_i → read lookup_index_i. Otherwise, if queue non-empty → read head index, go UPD_RD.
  - UPD_RD: port free for a lookup. Latch next counter computed from tbl_rdata_i; go UPD_WR.
  - UPD_WR: if the port is free or starved → write latched value to head index, pop queue, clear starve counter, go IDLE. Otherwise hold.
  - The starve counter increments each cycle a queued update is blocked by a lookup (IDLE with queue non-empty, or UPD_WR) and saturates at STARVE_LIMIT.
  - A starved cycle forces the update access; the lookup that cycle is not granted.
- Lookup response:
  - pred_valid_o is a register: 1 in the cycle after a granted lookup, else 0.
  - pred_taken_o = tbl_rdata_i[1] while pred_valid_o=1, else 0.
  - Fetch falls back to not-taken when pred_valid_o=0.
- Counter update: taken → increment, saturating at 2'b11; not taken → decrement, saturating at 2'b00.
- Queue:
  - Push on en_i & upd_valid_i & upd_ready_o; upd_ready_o = !full.
  - No push bypass when full, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full keeps the count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- No forwarding: a lookup to an index with a pending update reads the stale counter.
- en_i=0: no RAM access (tbl_en_o=0); FSM, sweep pointer, queue and starve counter hold; no push; pred_valid_o=0 next cycle.
- flush_i (acts regardless of en_i; rst_i dominates):
  - Next state INIT, sweep pointer 0, queue emptied, starve counter 0.
  - init_done_o=0 and pred_valid_o=0 next cycle.
  - An in-flight read-modify-write is abandoned; an update offered the same cycle is dropped.
- busy_o = (state==INIT) | queue non-empty; combinational.

Test Plan:
- Reset with INDEX_WIDTH=6 → 64 consecutive writes of 2'b01 to addresses 0..63, then init_done_o=1; a lookup issued during the sweep gets pred_valid_o=0.
- After init, push {idx=5, taken} twice with no lookups → read 5 / write 2'b10, then read 5 / write 2'b11. A later lookup of 5 → pred_valid_o=1, pred_taken_o=1 next cycle. Two more taken updates keep the counter at 2'b11.
- Push QUEUE_DEPTH+1 updates during INIT → upd_ready_o=0 after 4 pushes and the 5th is not accepted; after init, exactly 4 writes occur, in FIFO order.
- lookup_valid_i held 1 continuously with one queued update → after 8 blocked cycles the update write is forced; the lookup that cycle gets pred_valid_o=0 next cycle; normal lookups resume afterwards.
- Assert flush_i while in UPD_WR with 3 queued entries → no write to the head index, queue empty, sweep restarts at address 0, busy_o stays 1 until the sweep completes.
- Drop en_i for 3 cycles mid-sweep at address 20 → tbl_en_o=0 for those cycles, and the sweep resumes at address 20.

Source files
------------

// File: rtl/pht_if.sv
// Fetch lookup, decode update and table RAM signals of the pattern history controller.
// The controller connects through the slave modport; the surrounding pipeline and RAM use master.
interface pht_if #(
    parameter int INDEX_WIDTH = 6
);
    logic                   lookup_valid_i;
    logic [INDEX_WIDTH-1:0] lookup_index_i;
    logic                   pred_valid_o;
    logic                   pred_taken_o;
    logic                   upd_valid_i;
    logic [INDEX_WIDTH-1:0] upd_index_i;
    logic                   upd_taken_i;
    logic                   upd_ready_o;
    logic                   tbl_en_o;
    logic                   tbl_we_o;
    logic [INDEX_WIDTH-1:0] tbl_addr_o;
    logic [1:0]             tbl_wdata_o;
    logic [1:0]             tbl_rdata_i;

    modport master (
        output lookup_valid_i, lookup_index_i, upd_valid_i, upd_index_i, upd_taken_i, tbl_rdata_i,
        input  pred_valid_o, pred_taken_o, upd_ready_o, tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o
    );

    modport slave (
        input  lookup_valid_i, lookup_index_i, upd_valid_i, upd_index_i, upd_taken_i, tbl_rdata_i,
        output pred_valid_o, pred_taken_o, upd_ready_o, tbl_en_o, tbl_we_o, tbl_addr_o, tbl_wdata_o
    );
endinterface

// File: rtl/pht_ctrl.sv
// Single-port pattern history table controller: init sweep, lookup/update arbitration,
// saturating read-modify-write updates from a small FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_INIT   | sweeping every entry to weakly-not-taken, no lookups
// S_IDLE   | serving lookups, or starting the head update read
// S_UPD_RD | head counter arriving on rdata, port free for a lookup
// S_UPD_WR | waiting for a free (or starved) cycle to write back
module pht_ctrl #(
    parameter int INDEX_WIDTH  = 6,
    parameter int QUEUE_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  flush_i,
    pht_if.slave  pht,
    output logic  init_done_o,
    output logic  busy_o
);
    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_UPD_RD = 2'd2;
    localparam logic [1:0] S_UPD_WR = 2'd3;

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] Q_FULL  = CNT_W'(QUEUE_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    logic [1:0]             state, state_nx;
    logic [INDEX_WIDTH-1:0] sweep_ptr;
    logic [INDEX_WIDTH-1:0] q_idx [QUEUE_DEPTH];
    logic                   q_tkn [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       q_cnt;
    logic [STV_W-1:0]       starve_cnt;
    logic [1:0]             ctr_wb;
    logic                   pred_valid_q;
    logic                   init_done_q;

    logic                   act, q_empty, q_full, starved;
    logic                   push, pop, grant, blocked;
    logic                   tbl_en, tbl_we;
    logic [INDEX_WIDTH-1:0] tbl_addr;
    logic [1:0]             tbl_wdata;
    logic [1:0]             ctr_nx;

    // No table traffic while frozen, in reset, or on the flush cycle itself.
    assign act     = en_i & rst_i & ~flush_i;
    assign q_empty = (q_cnt == '0);
    assign q_full  = (q_cnt == Q_FULL);
    assign starved = (starve_cnt == STV_MAX);
    assign push    = act & pht.upd_valid_i & ~q_full;

    always_comb begin
        state_nx  = state;
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = sweep_ptr;
        tbl_wdata = 2'b01;
        grant     = 1'b0;
        pop       = 1'b0;
        blocked   = 1'b0;
        case (state)
            S_INIT: begin
                tbl_en = 1'b1;
                tbl_we = 1'b1;
                if (sweep_ptr == '1)
                    state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (pht.lookup_valid_i && !(starved && !q_empty)) begin
                    tbl_en   = 1'b1;
                    tbl_addr = pht.lookup_index_i;
                    grant    = 1'b1;
                    blocked  = ~q_empty;
                end else if (!q_empty) begin
                    tbl_en   = 1'b1;
                    tbl_addr = q_idx[rd_ptr];
                    state_nx = S_UPD_RD;
                end
            end
            S_UPD_RD: begin
                state_nx = S_UPD_WR;
                if (pht.lookup_valid_i) begin
                    tbl_en   = 1'b1;
                    tbl_addr = pht.lookup_index_i;
                    grant    = 1'b1;
                end
            end
            default: begin
                if (pht.lookup_valid_i && !starved) begin
                    tbl_en   = 1'b1;
                    tbl_addr = pht.lookup_index_i;
                    grant    = 1'b1;
                    blocked  = 1'b1;
                end else begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = q_idx[rd_ptr];
                    tbl_wdata = ctr_wb;
                    pop       = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
        endcase
        if (!act) begin
            state_nx = state;
            tbl_en   = 1'b0;
            tbl_we   = 1'b0;
            grant    = 1'b0;
            pop      = 1'b0;
            blocked  = 1'b0;
        end
    end

    always_comb begin
        ctr_nx = pht.tbl_rdata_i;
        if (q_tkn[rd_ptr]) begin
            if (pht.tbl_rdata_i != 2'b11)
                ctr_nx = pht.tbl_rdata_i + 2'd1;
        end else if (pht.tbl_rdata_i != 2'b00) begin
            ctr_nx = pht.tbl_rdata_i - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            state        <= S_INIT;
            sweep_ptr    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            starve_cnt   <= '0;
            ctr_wb       <= 2'b01;
            pred_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            pred_valid_q <= grant;
            if (en_i) begin
                state <= state_nx;
                if (state == S_INIT)
                    sweep_ptr <= sweep_ptr + INDEX_WIDTH'(1);
                if (state == S_INIT && state_nx == S_IDLE)
                    init_done_q <= 1'b1;
                if (state == S_UPD_RD)
                    ctr_wb <= ctr_nx;
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) begin
                    rd_ptr     <= rd_ptr + PTR_W'(1);
                    starve_cnt <= '0;
                end else if (blocked && !starved) begin
                    starve_cnt <= starve_cnt + STV_W'(1);
                end
                case ({push, pop})
                    2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                    2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                    default: q_cnt <= q_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_idx[wr_ptr] <= pht.upd_index_i;
            q_tkn[wr_ptr] <= pht.upd_taken_i;
        end
    end

    assign pht.tbl_en_o     = tbl_en;
    assign pht.tbl_we_o     = tbl_we;
    assign pht.tbl_addr_o   = tbl_addr;
    assign pht.tbl_wdata_o  = tbl_wdata;
    assign pht.upd_ready_o  = ~q_full;
    assign pht.pred_valid_o = pred_valid_q;
    assign pht.pred_taken_o = pred_valid_q & pht.tbl_rdata_i[1];
    assign init_done_o      = init_done_q;
    assign busy_o           = (state == S_INIT) | ~q_empty;
endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl: behavioural RAM, reference counter table, and
// scoreboards of expected update writes and expected predictions.
module tb_pht_ctrl;
    localparam int IW = 6;

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b0;
    logic en_i    = 1'b0;
    logic flush_i = 1'b0;
    logic init_done_o, busy_o;

    pht_if #(.INDEX_WIDTH(IW)) ifc ();

    pht_ctrl #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .flush_i     (flush_i),
        .pht         (ifc),
        .init_done_o (init_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [1:0] mem [64];
    always @(posedge clk_i) begin
        if (ifc.tbl_en_o) begin
            if (ifc.tbl_we_o) mem[ifc.tbl_addr_o] <= ifc.tbl_wdata_o;
            else              ifc.tbl_rdata_i <= mem[ifc.tbl_addr_o];
        end
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] ref_ctr [64];
    logic [7:0] exp_wr [$];
    logic       exp_pred [$];
    int         sweep_exp = 0;
    int         sweep_cnt = 0;
    int         iidx [5] = '{2, 9, 2, 40, 50};
    logic       itkn [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       gr [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    task automatic expect_upd(input int idx, input logic t);
        logic [1:0] c;
        c = next_ctr(ref_ctr[idx], t);
        ref_ctr[idx] = c;
        exp_wr.push_back({6'(idx), c});
    endtask

    task automatic push_upd(input int idx, input logic t);
        ifc.upd_valid_i = 1'b1;
        ifc.upd_index_i = 6'(idx);
        ifc.upd_taken_i = t;
        expect_upd(idx, t);
        cyc();
        ifc.upd_valid_i = 1'b0;
    endtask

    task automatic do_lookup(input int idx);
        logic [1:0] c;
        c = ref_ctr[idx];
        ifc.lookup_valid_i = 1'b1;
        ifc.lookup_index_i = 6'(idx);
        exp_pred.push_back(c[1]);
        cyc();
        chk("lookup_pred_valid", ifc.pred_valid_o, 1);
        ifc.lookup_valid_i = 1'b0;
        cyc();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_wr.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, exp_wr.size(), 0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done_o && n < 200) begin
            cyc();
            n++;
        end
        chk("init_done", init_done_o, 1);
    endtask

    // Scoreboard side: sweep writes checked in address order, update writes and predictions popped.
    always @(negedge clk_i) begin
        if (!rst_i || flush_i) begin
            sweep_exp = 0;
            sweep_cnt = 0;
        end else if (ifc.tbl_en_o && ifc.tbl_we_o) begin
            if (!init_done_o) begin
                chk("sweep_addr", ifc.tbl_addr_o, sweep_exp);
                chk("sweep_data", ifc.tbl_wdata_o, 2'b01);
                sweep_exp++;
                sweep_cnt++;
            end else begin
                chk("wr_pending", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0)
                    chk("upd_write", {ifc.tbl_addr_o, ifc.tbl_wdata_o}, exp_wr.pop_front());
            end
        end
        if (ifc.pred_valid_o) begin
            chk("pred_pending", exp_pred.size() > 0, 1);
            if (exp_pred.size() > 0)
                chk("pred_taken", ifc.pred_taken_o, exp_pred.pop_front());
        end else begin
            chk("pred_taken_idle", ifc.pred_taken_o, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_ctr[i] = 2'b01;
        ifc.lookup_valid_i = 1'b0;
        ifc.lookup_index_i = '0;
        ifc.upd_valid_i    = 1'b0;
        ifc.upd_index_i    = '0;
        ifc.upd_taken_i    = 1'b0;
        ifc.tbl_rdata_i    = 2'b00;
        en_i  = 1'b1;
        rst_i = 1'b0;
        cyc();
        cyc();
        chk("rst_pred_valid", ifc.pred_valid_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_tbl_en", ifc.tbl_en_o, 0);
        chk("rst_upd_ready", ifc.upd_ready_o, 1);
        chk("rst_busy", busy_o, 1);

        // Sweep: lookups ignored, five updates offered while the queue holds four.
        rst_i = 1'b1;
        #1;
        chk("sweep_first_addr", ifc.tbl_addr_o, 0);
        chk("sweep_first_we", ifc.tbl_we_o, 1);
        ifc.lookup_valid_i = 1'b1;
        ifc.lookup_index_i = 6'd3;
        for (int k = 0; k < 5; k++) begin
            ifc.upd_valid_i = 1'b1;
            ifc.upd_index_i = 6'(iidx[k]);
            ifc.upd_taken_i = itkn[k];
            #1;
            chk("init_upd_ready", ifc.upd_ready_o, (k < 4) ? 1 : 0);
            if (k < 4) expect_upd(iidx[k], itkn[k]);
            cyc();
            chk("init_pred_valid", ifc.pred_valid_o, 0);
        end
        ifc.upd_valid_i    = 1'b0;
        ifc.lookup_valid_i = 1'b0;
        repeat (15) cyc();

        // Freeze at sweep address 20.
        en_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("freeze_tbl_en", ifc.tbl_en_o, 0);
            cyc();
        end
        en_i = 1'b1;
        #1;
        chk("resume_addr", ifc.tbl_addr_o, 20);
        chk("resume_we", ifc.tbl_we_o, 1);
        wait_init();
        chk("sweep_count", sweep_cnt, 64);
        chk("full_after_init", ifc.upd_ready_o, 0);
        chk("busy_after_init", busy_o, 1);
        wait_drain("drain_init_queue");
        chk("idle_busy", busy_o, 0);

        // Saturating increments on index 5, then predictions.
        push_upd(5, 1'b1);
        push_upd(5, 1'b1);
        wait_drain("drain_idx5");
        do_lookup(5);
        do_lookup(9);
        do_lookup(2);
        do_lookup(40);
        do_lookup(63);
        push_upd(5, 1'b1);
        push_upd(5, 1'b1);
        wait_drain("drain_idx5_sat");
        do_lookup(5);

        // Starvation: continuous lookups against one queued update.
        push_upd(7, 1'b1);
        ifc.lookup_valid_i = 1'b1;
        ifc.lookup_index_i = 6'd10;
        for (int j = 0; j < 13; j++) begin
            if (j == 8) begin
                chk("starve_rd_addr", ifc.tbl_addr_o, 7);
                chk("starve_rd_we", ifc.tbl_we_o, 0);
            end
            if (j == 10) begin
                chk("starve_wr_addr", ifc.tbl_addr_o, 7);
                chk("starve_wr_we", ifc.tbl_we_o, 1);
            end
            if (gr[j]) exp_pred.push_back(ref_ctr[10][1]);
            cyc();
            chk("starve_pred_valid", ifc.pred_valid_o, gr[j]);
        end
        ifc.lookup_valid_i = 1'b0;
        cyc();
        chk("starve_drained", exp_wr.size(), 0);

        // Flush while holding in UPD_WR with three entries queued.
        ifc.lookup_valid_i = 1'b1;
        ifc.lookup_index_i = 6'd0;
        for (int p = 0; p < 3; p++) begin
            ifc.upd_valid_i = 1'b1;
            ifc.upd_index_i = 6'(11 + p);
            ifc.upd_taken_i = 1'b1;
            exp_pred.push_back(ref_ctr[0][1]);
            cyc();
        end
        ifc.upd_valid_i    = 1'b0;
        ifc.lookup_valid_i = 1'b0;
        #1;
        chk("rmw_read_addr", ifc.tbl_addr_o, 11);
        chk("rmw_read_we", ifc.tbl_we_o, 0);
        cyc();
        ifc.lookup_valid_i = 1'b1;
        exp_pred.push_back(ref_ctr[0][1]);
        cyc();
        exp_pred.push_back(ref_ctr[0][1]);
        #1;
        chk("upd_wr_hold_we", ifc.tbl_we_o, 0);
        cyc();
        flush_i         = 1'b1;
        ifc.upd_valid_i = 1'b1;
        ifc.upd_index_i = 6'd20;
        #1;
        chk("flush_tbl_en", ifc.tbl_en_o, 0);
        cyc();
        flush_i            = 1'b0;
        ifc.upd_valid_i    = 1'b0;
        ifc.lookup_valid_i = 1'b0;
        for (int i = 0; i < 64; i++) ref_ctr[i] = 2'b01;
        chk("flush_init_done", init_done_o, 0);
        chk("flush_pred_valid", ifc.pred_valid_o, 0);
        chk("flush_upd_ready", ifc.upd_ready_o, 1);
        chk("flush_sweep_addr", ifc.tbl_addr_o, 0);
        begin
            int n = 0;
            while (!init_done_o && n < 200) begin
                chk("flush_busy", busy_o, 1);
                cyc();
                n++;
            end
        end
        chk("reinit_done", init_done_o, 1);
        chk("reinit_sweep_count", sweep_cnt, 64);
        chk("reinit_busy", busy_o, 0);
        do_lookup(5);
        repeat (4) cyc();
        chk("final_wr_queue", exp_wr.size(), 0);
        chk("final_pred_queue", exp_pred.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
